// File: rtl/mem_seq_ctrl.sv
// mem_seq_ctrl: ROM->RAM fill then ROM+reversed-RAM sum streamer; drives rom_addr, RAM write/read ports, valid/ready result out, busy/done status
module mem_seq_ctrl #(
  parameter int DATA_WIDTH     = 8,
  parameter int ADDR_WIDTH     = 6,
  parameter int ROM_ADDR_WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [ROM_ADDR_WIDTH-1:0] base_addr,
  output logic                      busy,
  output logic                      done,
  output logic [ROM_ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0]     rom_data,
  output logic                      ram_we,
  output logic [ADDR_WIDTH-1:0]     ram_wr_addr,
  output logic [DATA_WIDTH-1:0]     ram_wr_data,
  output logic [ADDR_WIDTH-1:0]     ram_rd_addr,
  input  logic [DATA_WIDTH-1:0]     ram_q,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_WIDTH-1:0]     out_data,
  output logic [ADDR_WIDTH-1:0]     out_idx
);
  typedef enum logic [2:0] {IDLE, FILL, RD, CAP, OUT, DONE} state_t;
  localparam logic [ADDR_WIDTH-1:0] LAST = '1;
  state_t                    state_q, state_d;
  logic [ROM_ADDR_WIDTH-1:0] base_q, base_d;
  logic [ADDR_WIDTH-1:0]     i_q, i_d, j_q, j_d, out_idx_q, out_idx_d;
  logic [DATA_WIDTH-1:0]     rom_hold_q, rom_hold_d, out_data_q, out_data_d;
  logic                      out_valid_q, out_valid_d;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      base_q      <= '0;
      i_q         <= '0;
      j_q         <= '0;
      rom_hold_q  <= '0;
      out_data_q  <= '0;
      out_idx_q   <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      i_q         <= i_d;
      j_q         <= j_d;
      rom_hold_q  <= rom_hold_d;
      out_data_q  <= out_data_d;
      out_idx_q   <= out_idx_d;
      out_valid_q <= out_valid_d;
    end
  end
  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    i_d         = i_q;
    j_d         = j_q;
    rom_hold_d  = rom_hold_q;
    out_data_d  = out_data_q;
    out_idx_d   = out_idx_q;
    out_valid_d = out_valid_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = FILL;
        base_d  = base_addr;
        i_d     = '0;
        j_d     = '0;
      end
      FILL: begin
        i_d     = i_q + 1'b1;
        state_d = i_q == LAST ? RD : FILL;
      end
      RD: begin
        rom_hold_d = rom_data;
        state_d    = CAP;
      end
      CAP: begin
        out_data_d  = rom_hold_q + ram_q;
        out_idx_d   = j_q;
        out_valid_d = 1'b1;
        state_d     = OUT;
      end
      OUT: if (out_ready) begin
        out_valid_d = 1'b0;
        j_d         = j_q + 1'b1;
        state_d     = j_q == LAST ? DONE : RD;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  assign busy        = state_q != IDLE;
  assign done        = state_q == DONE;
  assign ram_we      = state_q == FILL;
  assign rom_addr    = state_q == FILL ? base_q + ROM_ADDR_WIDTH'(i_q) :
                       state_q == RD   ? base_q + ROM_ADDR_WIDTH'(j_q) : '0;
  assign ram_wr_addr = ram_we ? i_q : '0;
  assign ram_wr_data = ram_we ? rom_data : '0;
  assign ram_rd_addr = (state_q == RD || state_q == CAP) ? ~j_q : '0;
  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign out_idx     = out_idx_q;
endmodule

// File: tb/tb_mem_seq_ctrl.sv
// tb_mem_seq_ctrl: table-driven and randomized checks of mem_seq_ctrl against a ROM/RAM model and window-sum reference
module tb_mem_seq_ctrl;
  logic       clk = 1'b0, rst, start, out_ready;
  logic [7:0] base_addr, rom_addr, rom_data, ram_wr_data, ram_q, out_data;
  logic [5:0] ram_wr_addr, ram_rd_addr, out_idx;
  logic       busy, done, ram_we, out_valid;
  logic [7:0] rom [256];
  logic [7:0] ram [64];
  int total = 0, bad = 0;
  typedef struct {
    logic [7:0] base;
    int sidx;
    int slen;
    int val;
    int cyc;
    bit glitch;
  } vec_t;
  vec_t vecs[6];
  always #5 clk = ~clk;
  assign rom_data = rom[rom_addr];
  always @(posedge clk) begin
    if (ram_we) ram[ram_wr_addr] <= ram_wr_data;
    ram_q <= ram[ram_rd_addr];
  end
  mem_seq_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .busy(busy), .done(done),
    .rom_addr(rom_addr), .rom_data(rom_data), .ram_we(ram_we), .ram_wr_addr(ram_wr_addr),
    .ram_wr_data(ram_wr_data), .ram_rd_addr(ram_rd_addr), .ram_q(ram_q),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_idx(out_idx)
  );
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic int model(input int b, input int j);
    return (int'(rom[(b + j) % 256]) + int'(rom[(b + 63 - j) % 256])) % 256;
  endfunction
  task automatic rom_identity();
    for (int a = 0; a < 256; a++) rom[a] = 8'(a);
  endtask
  task automatic run(input vec_t v);
    int cyc = 0, res = 0, st = 0, bc = 0, dn = 0, wrong = 0;
    @(negedge clk);
    base_addr = v.base;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    while (cyc < 3000) begin
      @(negedge clk);
      cyc++;
      start = v.glitch && (cyc == 31 || (out_valid && res == 40));
      base_addr = start ? 8'h55 : v.base;
      if (busy) bc++;
      if (done) begin
        dn++;
        chk("done_cycle", 64'(cyc), 64'(v.cyc));
        break;
      end
      if (out_valid) begin
        chk("out_idx", 64'(out_idx), 64'(res));
        chk("out_data", 64'(out_data), 64'(model(int'(v.base), res)));
        if (v.val >= 0) chk("out_const", 64'(out_data), 64'(v.val));
        if (res == v.sidx && st < v.slen) begin
          out_ready = 1'b0;
          st++;
        end else begin
          out_ready = 1'b1;
          res++;
        end
      end else out_ready = 1'b1;
    end
    start = 1'b0;
    out_ready = 1'b1;
    chk("done_seen", 64'(dn), 64'd1);
    chk("results", 64'(res), 64'd64);
    chk("busy_cycles", 64'(bc), 64'(v.cyc));
    for (int k = 0; k < 64; k++) if (ram[k] !== rom[(int'(v.base) + k) % 256]) wrong++;
    chk("ram_window", 64'(wrong), 64'd0);
    @(negedge clk);
    chk("idle_after", 64'({busy, done, ram_we, out_valid}), 64'd0);
  endtask
  initial begin
    int dn, res;
    vec_t rv;
    rom_identity();
    vecs[0] = '{8'h00, -1, 0, 'h3F, 257, 1'b0};
    vecs[1] = '{8'hF0, -1, 0, 'h1F, 257, 1'b0};
    vecs[2] = '{8'h00, 10, 5, 'h3F, 262, 1'b0};
    vecs[3] = '{8'h10, 63, 3, 'h5F, 260, 1'b0};
    vecs[4] = '{8'h00, -1, 0, 'h3F, 257, 1'b1};
    vecs[5] = '{8'h80, 0, 2, 'h3F, 259, 1'b0};
    rst = 1'b1;
    start = 1'b1;
    out_ready = 1'b1;
    base_addr = 8'h33;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ctrl", 64'({busy, done, ram_we, out_valid}), 64'd0);
    chk("rst_data", 64'({out_data, out_idx, ram_wr_data}), 64'd0);
    chk("rst_addr", 64'({rom_addr, ram_rd_addr, ram_wr_addr}), 64'd0);
    start = 1'b0;
    rst = 1'b0;
    for (int v = 0; v < 6; v++) begin
      run(vecs[v]);
      if (v == 1) chk("ram16_wrap", 64'(ram[16]), 64'h00);
    end
    @(negedge clk);
    base_addr = 8'h00;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (21) @(negedge clk);
    chk("fill_i20", 64'({ram_we, ram_wr_addr}), 64'({1'b1, 6'd20}));
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("midrst", 64'({busy, ram_we, out_valid}), 64'd0);
    dn = 0;
    repeat (300) begin
      @(negedge clk);
      if (done || busy) dn++;
    end
    chk("midrst_quiet", 64'(dn), 64'd0);
    run(vecs[0]);
    @(negedge clk);
    base_addr = 8'h00;
    start = 1'b1;
    dn = 0;
    res = 0;
    for (int c = 0; c < 1200; c++) begin
      @(negedge clk);
      if (out_valid) begin
        chk("b2b_data", 64'(out_data), 64'h3F);
        res++;
      end
      if (done) begin
        dn++;
        @(negedge clk);
        chk("b2b_gap", 64'(busy), 64'd0);
        if (dn == 2) begin
          start = 1'b0;
          break;
        end
        @(negedge clk);
        chk("b2b_refill", 64'({busy, ram_we, ram_wr_addr}), 64'({1'b1, 1'b1, 6'd0}));
      end
    end
    chk("b2b_done", 64'(dn), 64'd2);
    chk("b2b_results", 64'(res), 64'd128);
    start = 1'b0;
    repeat (3) @(negedge clk);
    for (int r = 0; r < 3; r++) begin
      for (int a = 0; a < 256; a++) rom[a] = 8'($urandom);
      rv.base = 8'($urandom);
      rv.sidx = int'($urandom_range(0, 63));
      rv.slen = int'($urandom_range(0, 6));
      rv.val = -1;
      rv.cyc = 257 + rv.slen;
      rv.glitch = 1'b0;
      run(rv);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
